// File: rtl/bpu_pkg.sv
// Shared types and helpers for the bimodal branch predictor:
// 2-bit saturating counter encoding and its increment/decrement rules.
package bpu_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT       = 2'b00;
    localparam ctr_t WNT       = 2'b01;
    localparam ctr_t WT        = 2'b10;
    localparam ctr_t ST        = 2'b11;
    localparam ctr_t RESET_CTR = WNT;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bpu_bht.sv
// Branch history table: 2**IDX_BITS saturating counters, one combinational
// read port and one clocked train port (taken -> increment, else decrement).
module bpu_bht
    import bpu_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output ctr_t                rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_taken_i
);

    localparam int DEPTH = 2 ** IDX_BITS;

    ctr_t ctr_q [DEPTH];
    ctr_t ctr_d [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ctr
            assign ctr_d[gi] = (wr_en_i && (wr_idx_i == IDX_BITS'(gi)))
                             ? (wr_taken_i ? sat_inc(ctr_q[gi]) : sat_dec(ctr_q[gi]))
                             : ctr_q[gi];
        end
    endgenerate

    // Counters need a defined reset value, so this stays in flops rather than RAM.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= RESET_CTR;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Read sees the pre-update value when the same entry trains this cycle.
    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_prediction_unit.sv
// Bimodal branch predictor and flush controller for the PC select mux.
// Define BPU_STATS_EN to build the resolved-branch / mispredict counters.
module branch_prediction_unit
    import bpu_pkg::*;
#(
    parameter int IDX_BITS   = 6,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ID_IS_BRANCH,
    input  logic [31:0]           ID_PC,
    input  logic                  STALL,
    input  logic                  EX_BRANCH_TAKEN,
    output logic                  TAKE_BRANCH,
    output logic                  FLUSH,
    output logic                  EARLY_PREDICTION,
    output logic [STAT_WIDTH-1:0] BRANCH_COUNT,
    output logic [STAT_WIDTH-1:0] MISPREDICT_COUNT
);

    logic [IDX_BITS-1:0] id_idx;
    ctr_t                id_ctr;
    logic                resolve;

    logic                ex_valid_q, ex_valid_d;
    logic                ex_pred_q,  ex_pred_d;
    logic [IDX_BITS-1:0] ex_idx_q,   ex_idx_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{ID_PC[31:IDX_BITS+2], ID_PC[1:0]};

    assign id_idx = ID_PC[IDX_BITS+1:2];

    bpu_bht #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .CLK        (CLK),
        .RESET      (RESET),
        .rd_idx_i   (id_idx),
        .rd_ctr_o   (id_ctr),
        .wr_en_i    (resolve),
        .wr_idx_i   (ex_idx_q),
        .wr_taken_i (EX_BRANCH_TAKEN)
    );

    assign TAKE_BRANCH      = ID_IS_BRANCH & id_ctr[1];
    assign FLUSH            = ex_valid_q & (EX_BRANCH_TAKEN ^ ex_pred_q);
    assign EARLY_PREDICTION = ex_valid_q & ex_pred_q;

    // A mispredicted branch leaves EX even under stall, so it trains exactly once.
    assign resolve = ex_valid_q & (FLUSH | ~STALL);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pred_d  = ex_pred_q;
        ex_idx_d   = ex_idx_q;
        if (FLUSH) begin
            ex_valid_d = 1'b0;
        end else if (!STALL) begin
            ex_valid_d = ID_IS_BRANCH;
            ex_pred_d  = TAKE_BRANCH;
            ex_idx_d   = id_idx;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ex_valid_q <= 1'b0;
            ex_pred_q  <= 1'b0;
            ex_idx_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pred_q  <= ex_pred_d;
            ex_idx_q   <= ex_idx_d;
        end
    end

`ifdef BPU_STATS_EN
    logic [STAT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (resolve && FLUSH && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BRANCH_COUNT     = branch_cnt_q;
    assign MISPREDICT_COUNT = mispred_cnt_q;
`else
    assign BRANCH_COUNT     = '0;
    assign MISPREDICT_COUNT = '0;
`endif

endmodule
